fc_result_collector: RTL and testbench

- Consumes the final fully-connected layer's per-round result stream: the output-word strobe, the 36-bit signed score and the round-done pulse.
- For each round, computes the argmax class and its score, and tags the entry with the round index and an error bit.
- Buffers entries in a small first-word-fall-through (FWFT) FIFO and drains them to the host/AXI side over a valid/ready handshake.
- Tracks session completion once ROUNDS results have been produced.

---
 rtl/fc_result_collector.sv | 197 +++++++++++++++++++
 tb/tb_fc_result_collector.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_result_collector.sv
// fc_result_collector: per-round argmax of the final FC layer score stream.
// Each closed round becomes an entry {round, class, score, err}. Entries are
// held in a small first-word-fall-through FIFO and drained over valid/ready.
module fc_result_collector #(
   parameter int DATA_W      = 36,
   parameter int NUM_CLASSES = 2,
   parameter int CLS_W       = 1,
   parameter int ROUNDS      = 43,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     start_i,
   input  logic                     res_en_i,
   input  logic signed [DATA_W-1:0] res_data_i,
   input  logic                     round_done_i,
   output logic                     m_valid_o,
   input  logic                     m_ready_i,
   output logic [7:0]               m_round_o,
   output logic [CLS_W-1:0]         m_class_o,
   output logic signed [DATA_W-1:0] m_score_o,
   output logic                     m_err_o,
   output logic                     overflow_o,
   output logic                     session_done_o,
   output logic [7:0]               rounds_o
);

   localparam int CNT_W  = $clog2(NUM_CLASSES + 2);
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(NUM_CLASSES + 1);
   localparam logic [CNT_W-1:0]  CNT_EXP     = CNT_W'(NUM_CLASSES);
   localparam logic [7:0]        ROUNDS_LAST = 8'(ROUNDS - 1);
   localparam logic [FCNT_W-1:0] FIFO_FULL   = FCNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DONE} state_t;

   typedef struct packed {
      logic [7:0]        rnd;
      logic [CLS_W-1:0]  cls;
      logic [DATA_W-1:0] score;
      logic              err;
   } entry_t;

   // Word counter saturates one past the expected count so overruns stay flagged.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c >= CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
   endfunction

   state_t                     state_q, state_d;
   logic                       collecting;
   logic [CNT_W-1:0]           word_cnt_q, word_cnt_d, word_cnt_m;
   logic [CLS_W-1:0]           best_idx_q, best_idx_m;
   logic signed [DATA_W-1:0]   best_score_q, best_score_m;
   logic [7:0]                 rounds_q, rounds_d;
   logic                       overflow_q, overflow_d;
   logic                       ent_vld_q, ent_vld_d;
   entry_t                     ent_q;
   entry_t                     mem_q [FIFO_DEPTH];
   entry_t                     head;
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0]          fcnt_q, fcnt_d;
   logic                       acc, close, pop, push_ok;

   assign acc     = collecting && res_en_i && !start_i;
   assign close   = collecting && round_done_i && !start_i;
   assign pop     = m_valid_o && m_ready_i && !start_i;
   assign push_ok = ent_vld_q && !start_i && ((fcnt_q != FIFO_FULL) || pop);

   // Session state register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Session next state: start restarts from anywhere; last round close ends it.
   always_comb begin
      state_d = state_q;
      if (start_i)                             state_d = ST_COLLECT;
      else if (close && rounds_q == ROUNDS_LAST) state_d = ST_DONE;
   end

   // Session outputs decoded from state.
   always_comb begin
      collecting     = (state_q == ST_COLLECT);
      session_done_o = (state_q == ST_DONE);
   end

   // Running argmax including the word arriving this cycle, so a close in the
   // same cycle as the last word sees it.
   always_comb begin
      word_cnt_m   = word_cnt_q;
      best_idx_m   = best_idx_q;
      best_score_m = best_score_q;
      if (acc) begin
         if (word_cnt_q < CNT_EXP &&
             (word_cnt_q == '0 || res_data_i > best_score_q)) begin
            best_idx_m   = CLS_W'(word_cnt_q);
            best_score_m = res_data_i;
         end
         word_cnt_m = sat_inc(word_cnt_q);
      end
   end

   // Next-state for counters, flags and FIFO pointers.
   always_comb begin
      word_cnt_d = word_cnt_q;
      rounds_d   = rounds_q;
      overflow_d = overflow_q;
      ent_vld_d  = close;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fcnt_d     = fcnt_q;
      if (start_i) begin
         word_cnt_d = '0;
         rounds_d   = '0;
         overflow_d = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         fcnt_d     = '0;
      end else begin
         if (close) begin
            word_cnt_d = '0;
            rounds_d   = rounds_q + 8'd1;
         end else if (acc) begin
            word_cnt_d = word_cnt_m;
         end
         if (ent_vld_q && !push_ok) overflow_d = 1'b1;
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
            2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
            default: fcnt_d = fcnt_q;
         endcase
      end
   end

   // Control registers, cleared by the asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         word_cnt_q <= '0;
         rounds_q   <= '0;
         overflow_q <= 1'b0;
         ent_vld_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fcnt_q     <= '0;
      end else begin
         word_cnt_q <= word_cnt_d;
         rounds_q   <= rounds_d;
         overflow_q <= overflow_d;
         ent_vld_q  <= ent_vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fcnt_q     <= fcnt_d;
      end
   end

   // Datapath registers: running best, registered entry, FIFO storage.
   always_ff @(posedge clk_i) begin
      if (start_i || close) begin
         best_idx_q   <= '0;
         best_score_q <= '0;
      end else if (acc) begin
         best_idx_q   <= best_idx_m;
         best_score_q <= best_score_m;
      end
      if (close) begin
         ent_q.rnd   <= rounds_q;
         ent_q.cls   <= best_idx_m;
         ent_q.score <= best_score_m;
         ent_q.err   <= (word_cnt_m != CNT_EXP);
      end
      if (push_ok) mem_q[wr_ptr_q] <= ent_q;
   end

   assign m_valid_o  = (fcnt_q != '0);
   assign overflow_o = overflow_q;
   assign rounds_o   = rounds_q;

   // Head entry presented only while valid, so idle outputs read as zero.
   always_comb begin
      head      = mem_q[rd_ptr_q];
      m_round_o = '0;
      m_class_o = '0;
      m_score_o = '0;
      m_err_o   = 1'b0;
      if (m_valid_o) begin
         m_round_o = head.rnd;
         m_class_o = head.cls;
         m_score_o = $signed(head.score);
         m_err_o   = head.err;
      end
   end

endmodule

// File: tb/tb_fc_result_collector.sv
// Testbench for fc_result_collector: table vectors, hand sequences and a
// randomized run against a queue-based behavioural model.
module tb_fc_result_collector;

   logic                clk_i = 1'b0;
   logic                rst_n_i = 1'b0;
   logic                start_i = 1'b0;
   logic                res_en_i = 1'b0;
   logic signed [35:0]  res_data_i = '0;
   logic                round_done_i = 1'b0;
   logic                m_valid_o;
   logic                m_ready_i = 1'b0;
   logic [7:0]          m_round_o;
   logic [0:0]          m_class_o;
   logic signed [35:0]  m_score_o;
   logic                m_err_o;
   logic                overflow_o;
   logic                session_done_o;
   logic [7:0]          rounds_o;

   fc_result_collector dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .start_i        (start_i),
      .res_en_i       (res_en_i),
      .res_data_i     (res_data_i),
      .round_done_i   (round_done_i),
      .m_valid_o      (m_valid_o),
      .m_ready_i      (m_ready_i),
      .m_round_o      (m_round_o),
      .m_class_o      (m_class_o),
      .m_score_o      (m_score_o),
      .m_err_o        (m_err_o),
      .overflow_o     (overflow_o),
      .session_done_o (session_done_o),
      .rounds_o       (rounds_o)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [7:0]  rnd;
      logic        cls;
      logic [35:0] score;
      logic        err;
   } ent_t;

   // Behavioural model state
   ent_t               mfifo[$];
   logic signed [35:0] mwords[$];
   int                 mrounds;
   bit                 mcoll, mdone, movf, mpend_v;
   ent_t               mpend;
   int                 pop_seen;

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Entry from the words gathered in a round: argmax over the first two words.
   function automatic ent_t make_entry(input int rnd);
      ent_t e;
      int   n;
      n       = mwords.size();
      e.rnd   = 8'(rnd);
      e.cls   = 1'b0;
      e.score = '0;
      e.err   = (n != 2);
      for (int i = 0; i < n && i < 2; i++)
         if (i == 0 || mwords[i] > $signed(e.score)) begin
            e.cls   = 1'(i);
            e.score = mwords[i];
         end
      return e;
   endfunction

   task automatic model_clear();
      mfifo.delete();
      mwords.delete();
      mrounds = 0;
      mcoll   = 0;
      mdone   = 0;
      movf    = 0;
      mpend_v = 0;
   endtask

   task automatic model_chk();
      chk("m_valid", m_valid_o, mfifo.size() > 0);
      if (mfifo.size() > 0) begin
         chk("m_round", m_round_o, mfifo[0].rnd);
         chk("m_class", m_class_o, mfifo[0].cls);
         chk("m_score", m_score_o, $signed(mfifo[0].score));
         chk("m_err",   m_err_o,   mfifo[0].err);
      end
      chk("overflow",     overflow_o,     movf);
      chk("session_done", session_done_o, mdone);
      chk("rounds",       rounds_o,       mrounds);
   endtask

   // One clock cycle: drive inputs, advance the model at the edge, compare.
   task automatic step(input bit st, input bit en, input logic signed [35:0] d,
                       input bit rd, input bit rdy);
      bit pop;
      start_i = st; res_en_i = en; res_data_i = d; round_done_i = rd; m_ready_i = rdy;
      if (m_valid_o && rdy && !st) pop_seen++;
      pop = (mfifo.size() > 0) && rdy;
      @(posedge clk_i);
      if (st) begin
         mfifo.delete();
         mwords.delete();
         mrounds = 0;
         movf    = 0;
         mpend_v = 0;
         mcoll   = 1;
         mdone   = 0;
      end else begin
         if (pop) void'(mfifo.pop_front());
         if (mpend_v) begin
            if (mfifo.size() < 4) mfifo.push_back(mpend);
            else                  movf = 1;
         end
         mpend_v = 0;
         if (mcoll) begin
            if (en) mwords.push_back(d);
            if (rd) begin
               mpend   = make_entry(mrounds);
               mpend_v = 1;
               mwords.delete();
               mrounds++;
               if (mrounds == 43) begin
                  mcoll = 0;
                  mdone = 1;
               end
            end
         end
      end
      #1;
      model_chk();
   endtask

   task automatic idle(input bit rdy);
      step(0, 0, '0, 0, rdy);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"},    m_valid_o,      0);
      chk({tag, "_round"},    m_round_o,      0);
      chk({tag, "_class"},    m_class_o,      0);
      chk({tag, "_score"},    m_score_o,      0);
      chk({tag, "_err"},      m_err_o,        0);
      chk({tag, "_overflow"}, overflow_o,     0);
      chk({tag, "_done"},     session_done_o, 0);
      chk({tag, "_rounds"},   rounds_o,       0);
   endtask

   task automatic do_reset();
      rst_n_i = 1'b0; start_i = 0; res_en_i = 0; round_done_i = 0; m_ready_i = 0;
      repeat (2) @(posedge clk_i);
      #1;
      chk_all_zero("reset");
      model_clear();
      rst_n_i = 1'b1;
   endtask

   typedef struct {
      int                 n;
      logic signed [35:0] w0, w1, w2;
      logic               cls;
      logic signed [35:0] score;
      logic               err;
   } vec_t;

   vec_t vecs [7];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{2, 36'sd100, -36'sd5, 36'sd0, 1'b0, 36'sd100, 1'b0};
      vecs[1] = '{2, -36'sd7, -36'sd3, 36'sd0, 1'b1, -36'sd3, 1'b0};
      vecs[2] = '{2, 36'sd42, 36'sd42, 36'sd0, 1'b0, 36'sd42, 1'b0};
      vecs[3] = '{1, 36'sd9, 36'sd0, 36'sd0, 1'b0, 36'sd9, 1'b1};
      vecs[4] = '{3, 36'sd1, 36'sd2, 36'sd50, 1'b1, 36'sd2, 1'b1};
      vecs[5] = '{0, 36'sd0, 36'sd0, 36'sd0, 1'b0, 36'sd0, 1'b1};
      vecs[6] = '{2, 36'sh800000000, 36'sh7FFFFFFFF, 36'sd0, 1'b1, 36'sh7FFFFFFFF, 1'b0};

      model_clear();
      pop_seen = 0;
      do_reset();

      // Words before start are ignored in IDLE.
      step(0, 1, 36'sd77, 1, 1);
      idle(1);
      chk("idle_no_entry", m_valid_o, 0);

      // Table vectors, one round each, m_ready high.
      step(1, 0, '0, 0, 1);
      for (int v = 0; v < 7; v++) begin
         logic signed [35:0] w [3];
         w[0] = vecs[v].w0; w[1] = vecs[v].w1; w[2] = vecs[v].w2;
         if (vecs[v].n == 0) step(0, 0, '0, 1, 1);
         for (int i = 0; i < vecs[v].n; i++)
            step(0, 1, w[i], (i == vecs[v].n - 1), 1);
         chk("vec_valid_early", m_valid_o, 0);
         idle(1);
         chk("vec_valid", m_valid_o, 1);
         chk("vec_round", m_round_o, v);
         chk("vec_class", m_class_o, vecs[v].cls);
         chk("vec_score", m_score_o, vecs[v].score);
         chk("vec_err",   m_err_o,   vecs[v].err);
         idle(1);
      end

      // Backpressure and overflow: six rounds with the consumer stalled.
      step(1, 0, '0, 0, 0);
      for (int r = 0; r < 6; r++) begin
         step(0, 1, 36'(10 * r + 1), 0, 0);
         step(0, 1, -36'(r), 1, 0);
      end
      idle(0);
      idle(0);
      chk("bp_overflow", overflow_o, 1);
      chk("bp_rounds", rounds_o, 6);
      for (int k = 0; k < 3; k++) begin
         chk("bp_stall_valid", m_valid_o, 1);
         chk("bp_stall_round", m_round_o, 0);
         chk("bp_stall_score", m_score_o, 1);
         idle(0);
      end
      for (int i = 0; i < 4; i++) begin
         chk("bp_drain_valid", m_valid_o, 1);
         chk("bp_drain_round", m_round_o, i);
         chk("bp_drain_score", m_score_o, 10 * i + 1);
         idle(1);
      end
      chk("bp_drained", m_valid_o, 0);

      // Full session of 43 rounds.
      step(1, 0, '0, 0, 1);
      pop_seen = 0;
      for (int r = 0; r < 43; r++) begin
         step(0, 1, 36'($signed($urandom_range(0, 1000)) - 500), 0, 1);
         step(0, 1, 36'($signed($urandom_range(0, 1000)) - 500), 1, 1);
      end
      idle(1);
      idle(1);
      idle(1);
      chk("sess_entries", pop_seen, 43);
      chk("sess_done", session_done_o, 1);
      chk("sess_rounds", rounds_o, 43);
      step(0, 1, 36'sd5, 0, 1);
      step(0, 1, 36'sd6, 1, 1);
      idle(1);
      idle(1);
      chk("done_no_entry", pop_seen, 43);
      chk("done_valid", m_valid_o, 0);
      step(1, 0, '0, 0, 1);
      chk("restart_rounds", rounds_o, 0);
      chk("restart_done", session_done_o, 0);

      // Restart mid-session with a partial round and a non-empty FIFO.
      for (int r = 0; r < 5; r++) begin
         step(0, 1, 36'sd1, 0, 0);
         step(0, 1, 36'sd2, 1, 0);
      end
      step(0, 1, 36'sd7, 0, 0);
      step(1, 0, '0, 0, 0);
      chk("mid_flush_valid", m_valid_o, 0);
      chk("mid_flush_ovf", overflow_o, 0);
      chk("mid_flush_rounds", rounds_o, 0);
      step(0, 1, 36'sd3, 0, 1);
      step(0, 1, 36'sd8, 1, 1);
      idle(1);
      chk("mid_round", m_round_o, 0);
      chk("mid_class", m_class_o, 1);
      chk("mid_score", m_score_o, 8);
      chk("mid_err", m_err_o, 0);

      // Asynchronous reset in the middle of a round with a live entry.
      step(0, 1, 36'sd4, 0, 0);
      step(0, 1, 36'sd4, 1, 0);
      idle(0);
      step(0, 1, 36'sd11, 0, 0);
      rst_n_i = 1'b0;
      #1;
      chk_all_zero("async_rst");
      model_clear();
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      idle(1);

      // Randomized traffic against the model.
      step(1, 0, '0, 0, 1);
      for (int c = 0; c < 600; c++) begin
         logic [63:0]        raw;
         logic signed [35:0] d;
         int                 s;
         if ($urandom_range(0, 2) == 0) begin
            s = int'($urandom_range(0, 6)) - 3;
            d = 36'(s);
         end else begin
            raw = {$urandom(), $urandom()};
            d   = raw[35:0];
         end
         step($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1, d,
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
